// File: rtl/tdc_ctrl_pkg.sv
// tdc_ctrl_pkg: shared state encoding, width helpers and defaults for the TDC measurement sequencer.
package tdc_ctrl_pkg;

    typedef enum logic [2:0] {
        IDLE,
        ARM,
        LAUNCH,
        CAPTURE,
        WAIT,
        RELAX,
        DONE
    } state_e;

    localparam int TIMEOUT_DEF    = 15;
    localparam int MAX_LOG2_S_DEF = 7;

    // A Hamming weight over n taps ranges 0..n, so it needs one bit more than $clog2(n).
    function automatic int hw_width(input int n);
        return $clog2(n) + 1;
    endfunction

    // Sum of 2^max_log2_s samples of at most n each never overflows this width.
    function automatic int acc_width(input int hw_w, input int max_log2_s);
        return hw_w + max_log2_s;
    endfunction

endpackage

// File: rtl/tdc_hw_stats.sv
// tdc_hw_stats: running sum, minimum and maximum of accepted Hamming-weight samples.
//   clk, rst_n : clock, asynchronous active-low reset (all registers to 0)
//   clr        : start of burst; loads sum=0, min=N, max=0
//   acc_en     : fold hw_i into the statistics this cycle
//   hw_i       : sample value
//   acc_sum, hw_min, hw_max : registered results
module tdc_hw_stats
    import tdc_ctrl_pkg::*;
#(
    parameter int N     = 64,
    parameter int HW_W  = hw_width(N),
    parameter int ACC_W = acc_width(HW_W, MAX_LOG2_S_DEF)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             acc_en,
    input  logic [HW_W-1:0]  hw_i,
    output logic [ACC_W-1:0] acc_sum,
    output logic [HW_W-1:0]  hw_min,
    output logic [HW_W-1:0]  hw_max
);

    logic [ACC_W-1:0] acc_sum_q, acc_sum_d;
    logic [HW_W-1:0]  hw_min_q, hw_min_d;
    logic [HW_W-1:0]  hw_max_q, hw_max_d;

    always_comb begin
        acc_sum_d = clr ? '0 : acc_en ? acc_sum_q + ACC_W'(hw_i) : acc_sum_q;
        hw_min_d  = clr ? HW_W'(N) : (acc_en && hw_i < hw_min_q) ? hw_i : hw_min_q;
        hw_max_d  = clr ? '0 : (acc_en && hw_i > hw_max_q) ? hw_i : hw_max_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_sum_q <= '0;
            hw_min_q  <= '0;
            hw_max_q  <= '0;
        end else begin
            acc_sum_q <= acc_sum_d;
            hw_min_q  <= hw_min_d;
            hw_max_q  <= hw_max_d;
        end
    end

    assign acc_sum = acc_sum_q;
    assign hw_min  = hw_min_q;
    assign hw_max  = hw_max_q;

endmodule

// File: rtl/tdc_meas_seq.sv
// tdc_meas_seq: sequences launch/capture edges to the NAND-delay-line TDC and collects a 2^k sample burst.
//   clk, rst_n           : clock, asynchronous active-low reset
//   start                : request a burst (honoured in IDLE only)
//   cfg_dly, cfg_log2_s  : launch-to-capture offset (0 acts as 1), burst exponent k
//   clk_launch, clk_capture, val_in_o : registered drives to the TDC
//   hw_i, val_out_i      : TDC result
//   busy, done           : burst in progress / one-cycle completion pulse
//   acc_sum, hw_min, hw_max, timeout_err : burst results
module tdc_meas_seq
    import tdc_ctrl_pkg::*;
#(
    parameter int N          = 64,
    parameter int HW_W       = hw_width(N),
    parameter int DLY_W      = 4,
    parameter int MAX_LOG2_S = MAX_LOG2_S_DEF,
    parameter int TIMEOUT    = TIMEOUT_DEF
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       start,
    input  logic [DLY_W-1:0]           cfg_dly,
    input  logic [2:0]                 cfg_log2_s,
    output logic                       clk_launch,
    output logic                       clk_capture,
    output logic                       val_in_o,
    input  logic [HW_W-1:0]            hw_i,
    input  logic                       val_out_i,
    output logic                       busy,
    output logic                       done,
    output logic [HW_W+MAX_LOG2_S-1:0] acc_sum,
    output logic [HW_W-1:0]            hw_min,
    output logic [HW_W-1:0]            hw_max,
    output logic                       timeout_err
);

    localparam int ACC_W = acc_width(HW_W, MAX_LOG2_S);
    localparam int SC_W  = MAX_LOG2_S + 1;
    localparam int TO_W  = $clog2(TIMEOUT + 1);

    state_e           state_q, state_d;
    logic [DLY_W-1:0] cfg_dly_q, cfg_dly_d;
    logic [2:0]       k_q, k_d;
    logic [DLY_W-1:0] dly_cnt_q, dly_cnt_d;
    logic [TO_W-1:0]  to_cnt_q, to_cnt_d;
    logic [SC_W-1:0]  samp_cnt_q, samp_cnt_d;
    logic             timeout_err_q, timeout_err_d;
    logic             clk_launch_q, clk_launch_d;
    logic             clk_capture_q, clk_capture_d;
    logic             val_in_q, val_in_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             clr, acc_en;
    logic [SC_W-1:0]  samp_tgt;

    assign samp_tgt = SC_W'(1) << k_q;

    always_comb begin
        state_d       = state_q;
        cfg_dly_d     = cfg_dly_q;
        k_d           = k_q;
        dly_cnt_d     = dly_cnt_q;
        to_cnt_d      = to_cnt_q;
        samp_cnt_d    = samp_cnt_q;
        timeout_err_d = timeout_err_q;
        clr           = 1'b0;
        acc_en        = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    cfg_dly_d     = (cfg_dly == '0) ? DLY_W'(1) : cfg_dly;
                    k_d           = cfg_log2_s;
                    samp_cnt_d    = '0;
                    timeout_err_d = 1'b0;
                    clr           = 1'b1;
                    state_d       = ARM;
                end
            end
            ARM: begin
                dly_cnt_d = DLY_W'(1);
                state_d   = LAUNCH;
            end
            LAUNCH: begin
                if (dly_cnt_q == cfg_dly_q) state_d = CAPTURE;
                else dly_cnt_d = dly_cnt_q + DLY_W'(1);
            end
            CAPTURE: begin
                to_cnt_d = '0;
                state_d  = WAIT;
            end
            WAIT: begin
                if (val_out_i) begin
                    acc_en     = 1'b1;
                    samp_cnt_d = samp_cnt_q + SC_W'(1);
                    state_d    = RELAX;
                end else if (to_cnt_q == TO_W'(TIMEOUT - 1)) begin
                    timeout_err_d = 1'b1;
                    state_d       = DONE;
                end else begin
                    to_cnt_d = to_cnt_q + TO_W'(1);
                end
            end
            RELAX:   state_d = (samp_cnt_q == samp_tgt) ? DONE : ARM;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
        // Outputs are decoded from the next state so the registered copies line up with the state they describe.
        clk_launch_d  = (state_d == LAUNCH) || (state_d == CAPTURE);
        clk_capture_d = (state_d == CAPTURE);
        val_in_d      = (state_d == ARM) || (state_d == LAUNCH) || (state_d == CAPTURE);
        busy_d        = (state_d != IDLE) && (state_d != DONE);
        done_d        = (state_d == DONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            cfg_dly_q     <= '0;
            k_q           <= '0;
            dly_cnt_q     <= '0;
            to_cnt_q      <= '0;
            samp_cnt_q    <= '0;
            timeout_err_q <= 1'b0;
            clk_launch_q  <= 1'b0;
            clk_capture_q <= 1'b0;
            val_in_q      <= 1'b0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            cfg_dly_q     <= cfg_dly_d;
            k_q           <= k_d;
            dly_cnt_q     <= dly_cnt_d;
            to_cnt_q      <= to_cnt_d;
            samp_cnt_q    <= samp_cnt_d;
            timeout_err_q <= timeout_err_d;
            clk_launch_q  <= clk_launch_d;
            clk_capture_q <= clk_capture_d;
            val_in_q      <= val_in_d;
            busy_q        <= busy_d;
            done_q        <= done_d;
        end
    end

    tdc_hw_stats #(
        .N     (N),
        .HW_W  (HW_W),
        .ACC_W (ACC_W)
    ) u_stats (
        .clk     (clk),
        .rst_n   (rst_n),
        .clr     (clr),
        .acc_en  (acc_en),
        .hw_i    (hw_i),
        .acc_sum (acc_sum),
        .hw_min  (hw_min),
        .hw_max  (hw_max)
    );

    assign clk_launch  = clk_launch_q;
    assign clk_capture = clk_capture_q;
    assign val_in_o    = val_in_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign timeout_err = timeout_err_q;

endmodule

// File: tb/tb_tdc_meas_seq.sv
// tb_tdc_meas_seq: table-driven and randomized checks of tdc_meas_seq against a burst-level reference model.
module tb_tdc_meas_seq;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [3:0]  cfg_dly = '0;
    logic [2:0]  cfg_log2_s = '0;
    logic        clk_launch, clk_capture, val_in_o;
    logic [6:0]  hw_i = '0;
    logic        val_out_i = 1'b0;
    logic        busy, done, timeout_err;
    logic [13:0] acc_sum;
    logic [6:0]  hw_min, hw_max;

    int n_cmp = 0;
    int n_bad = 0;
    int hw_q[$];
    int lat_q[$];
    int launch_cnt = 0, cap_cnt = 0, done_cnt = 0;

    tdc_meas_seq dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .cfg_dly     (cfg_dly),
        .cfg_log2_s  (cfg_log2_s),
        .clk_launch  (clk_launch),
        .clk_capture (clk_capture),
        .val_in_o    (val_in_o),
        .hw_i        (hw_i),
        .val_out_i   (val_out_i),
        .busy        (busy),
        .done        (done),
        .acc_sum     (acc_sum),
        .hw_min      (hw_min),
        .hw_max      (hw_max),
        .timeout_err (timeout_err)
    );

    always #5 clk = ~clk;

    always begin
        @(posedge clk);
        #1;
        launch_cnt += int'(clk_launch);
        cap_cnt    += int'(clk_capture);
        done_cnt   += int'(done);
    end

    // TDC stand-in: a capture edge consumes one {hw, latency} pair; latency L raises val_out in the L-th WAIT cycle,
    // latency 0 never answers. Stray val_out pulses are thrown in while the sequencer is idle or arming.
    int   cd = -1;
    int   cur_hw = 0;
    always begin
        @(posedge clk);
        #1;
        val_out_i = 1'b0;
        hw_i = 7'($urandom);
        if (!rst_n) cd = -1;
        else if (clk_capture) begin
            cd = (lat_q.size() > 0) ? lat_q.pop_front() : 0;
            cur_hw = (hw_q.size() > 0) ? hw_q.pop_front() : 0;
            if (cd == 0) cd = -1;
        end else if (cd > 0) begin
            cd--;
            if (cd == 0) begin
                val_out_i = 1'b1;
                hw_i = 7'(cur_hw);
                cd = -1;
            end
        end else if ((!busy || (val_in_o && !clk_launch)) && $urandom_range(0, 3) == 0) begin
            val_out_i = 1'b1;
        end
    end

    task automatic chk(input string nm, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic run_vec(input string nm, input int d, input int k, input int e_sum, input int e_min,
                           input int e_max, input int e_to, input int e_cyc, input int e_l, input int e_c);
        int l0, c0, d0, cyc;
        bit seen;
        l0 = launch_cnt; c0 = cap_cnt; d0 = done_cnt;
        cfg_dly = 4'(d); cfg_log2_s = 3'(k); start = 1'b1;
        @(posedge clk); #2;
        start = 1'b0;
        cfg_dly = 4'($urandom); cfg_log2_s = 3'($urandom);
        chk({nm, " busy_at_arm"}, int'(busy), 1);
        chk({nm, " to_cleared"}, int'(timeout_err), 0);
        cyc = 1;
        seen = done;
        while (!seen && cyc < 4000) begin
            @(posedge clk); #2;
            cyc++;
            seen = done;
        end
        chk({nm, " cycles_to_done"}, seen ? cyc : -1, e_cyc);
        chk({nm, " sum"}, int'(acc_sum), e_sum);
        chk({nm, " min"}, int'(hw_min), e_min);
        chk({nm, " max"}, int'(hw_max), e_max);
        chk({nm, " timeout_err"}, int'(timeout_err), e_to);
        chk({nm, " busy_in_done"}, int'(busy), 0);
        @(posedge clk); #2;
        chk({nm, " done_one_cycle"}, int'(done), 0);
        chk({nm, " launch_cycles"}, launch_cnt - l0, e_l);
        chk({nm, " captures"}, cap_cnt - c0, e_c);
        chk({nm, " done_pulses"}, done_cnt - d0, 1);
        hw_q.delete();
        lat_q.delete();
    endtask

    typedef struct packed {
        int             dly;
        int             k;
        logic [3:0][7:0] hw;
        logic [3:0][7:0] lat;
        int             e_sum, e_min, e_max, e_to, e_cyc, e_l, e_c;
    } vec_t;

    vec_t tbl[6];

    function automatic vec_t mk(input int d, input int k, input int h0, input int h1, input int h2, input int h3,
                                input int l0, input int l1, input int l2, input int l3, input int s, input int mn,
                                input int mx, input int to, input int cyc, input int lc, input int cc);
        vec_t v;
        v.dly = d; v.k = k;
        v.hw = {8'(h3), 8'(h2), 8'(h1), 8'(h0)};
        v.lat = {8'(l3), 8'(l2), 8'(l1), 8'(l0)};
        v.e_sum = s; v.e_min = mn; v.e_max = mx; v.e_to = to; v.e_cyc = cyc; v.e_l = lc; v.e_c = cc;
        return v;
    endfunction

    task automatic load_tbl(input vec_t v);
        for (int i = 0; i < 4; i++) begin
            hw_q.push_back(int'(v.hw[i]));
            lat_q.push_back(int'(v.lat[i]));
        end
    endtask

    // Burst-level model: each answered sample costs ARM + d launch cycles + capture + L wait + RELAX;
    // an unanswered one costs ARM + d + capture + 15 wait and ends the burst; DONE adds one more.
    task automatic rand_burst(input int idx);
        int d, k, dd, n, sum, mn, mx, to, cyc, lc, cc;
        int hws[$], lats[$];
        d = $urandom_range(0, 15);
        k = (idx == 0) ? 7 : $urandom_range(0, 3);
        n = 1 << k;
        dd = (d == 0) ? 1 : d;
        sum = 0; mn = 64; mx = 0; to = 0; cyc = 1; lc = 0; cc = 0;
        for (int i = 0; i < n; i++) begin
            hws.push_back($urandom_range(0, 64));
            lats.push_back(($urandom_range(0, 9) == 0) ? 0 : $urandom_range(1, 6));
        end
        for (int i = 0; i < n; i++) begin
            lc += dd + 1;
            cc++;
            if (lats[i] == 0) begin
                cyc += 2 + dd + 15;
                to = 1;
                break;
            end
            cyc += 3 + dd + lats[i];
            sum += hws[i];
            if (hws[i] < mn) mn = hws[i];
            if (hws[i] > mx) mx = hws[i];
        end
        hw_q = hws;
        lat_q = lats;
        run_vec($sformatf("rand%0d", idx), d, k, sum, mn, mx, to, cyc, lc, cc);
    endtask

    initial begin
        int c0, d0, l0;
        bit seen;
        tbl[0] = mk(3, 0, 37, 0, 0, 0, 2, 0, 0, 0, 37, 37, 37, 0, 9, 4, 1);
        tbl[1] = mk(2, 2, 10, 40, 25, 64, 1, 3, 2, 1, 139, 10, 64, 0, 28, 12, 4);
        tbl[2] = mk(0, 1, 5, 0, 0, 0, 1, 1, 0, 0, 5, 0, 5, 0, 11, 4, 2);
        tbl[3] = mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 64, 0, 1, 19, 2, 1);
        tbl[4] = mk(15, 1, 63, 1, 0, 0, 4, 1, 0, 0, 64, 1, 63, 0, 42, 32, 2);
        tbl[5] = mk(2, 2, 20, 30, 0, 0, 1, 0, 0, 0, 20, 20, 20, 1, 26, 6, 2);

        repeat (3) @(posedge clk);
        #2;
        chk("reset busy", int'(busy), 0);
        chk("reset done", int'(done), 0);
        chk("reset launch", int'(clk_launch), 0);
        chk("reset val_in", int'(val_in_o), 0);
        chk("reset sum", int'(acc_sum), 0);
        chk("reset min", int'(hw_min), 0);
        chk("reset timeout_err", int'(timeout_err), 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #2;

        for (int i = 0; i < 6; i++) begin
            load_tbl(tbl[i]);
            run_vec($sformatf("vec%0d", i), tbl[i].dly, tbl[i].k, tbl[i].e_sum, tbl[i].e_min, tbl[i].e_max,
                    tbl[i].e_to, tbl[i].e_cyc, tbl[i].e_l, tbl[i].e_c);
        end

        // start in WAIT and in DONE must not launch another burst
        c0 = cap_cnt; d0 = done_cnt;
        hw_q.push_back(33); lat_q.push_back(6);
        cfg_dly = 4'd1; cfg_log2_s = 3'd0; start = 1'b1;
        @(posedge clk); #2;
        start = 1'b0;
        seen = 0;
        for (int i = 0; i < 50 && !seen; i++) begin
            @(posedge clk); #2;
            seen = clk_capture;
        end
        chk("ign capture_seen", int'(seen), 1);
        @(posedge clk); #2;
        start = 1'b1;
        @(posedge clk); #2;
        start = 1'b0;
        seen = 0;
        for (int i = 0; i < 50 && !seen; i++) begin
            @(posedge clk); #2;
            seen = done;
        end
        chk("ign done_seen", int'(seen), 1);
        start = 1'b1;
        @(posedge clk); #2;
        start = 1'b0;
        repeat (30) @(posedge clk);
        #2;
        chk("ign captures", cap_cnt - c0, 1);
        chk("ign done_pulses", done_cnt - d0, 1);
        chk("ign sum", int'(acc_sum), 33);
        chk("ign busy", int'(busy), 0);
        hw_q.delete(); lat_q.delete();

        // asynchronous reset while launching
        hw_q.push_back(50); lat_q.push_back(2);
        cfg_dly = 4'd10; cfg_log2_s = 3'd0; start = 1'b1;
        @(posedge clk); #2;
        start = 1'b0;
        repeat (3) @(posedge clk);
        #3;
        chk("rst launch_before", int'(clk_launch), 1);
        rst_n = 1'b0;
        #1;
        chk("rst launch_async", int'(clk_launch), 0);
        chk("rst val_in_async", int'(val_in_o), 0);
        chk("rst busy_async", int'(busy), 0);
        chk("rst min_async", int'(hw_min), 0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        hw_q.delete(); lat_q.delete();
        @(posedge clk); #2;
        l0 = launch_cnt;
        chk("rst idle_after", int'(busy) + int'(clk_launch), 0);
        load_tbl(tbl[0]);
        run_vec("post_rst", tbl[0].dly, tbl[0].k, tbl[0].e_sum, tbl[0].e_min, tbl[0].e_max,
                tbl[0].e_to, tbl[0].e_cyc, tbl[0].e_l, tbl[0].e_c);

        for (int i = 0; i < 8; i++) rand_burst(i);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/tdc_meas_seq.md
Name: tdc_meas_seq

Overview:
- On-chip sequencer for the NAND-delay-line TDC core (launch/capture clocks, val handshake, Hamming-weight readout).
- Generates the launch/capture edge pair with a programmable cycle offset.
- Collects a burst of 2^k Hamming-weight samples and reports the sum, minimum and maximum.
- Replaces host bit-banging of ui_in[0], ui_in[1] and ui_in[6]. The pulse-generator controls (pg_*) stay outside this block.

Parameters:
- N, 64, delay-line tap count; must match the TDC core.
- HW_W, $clog2(N)+1, Hamming-weight width (7 for N=64).
- DLY_W, 4, width of the launch-to-capture delay field.
- MAX_LOG2_S, 7, largest burst exponent; at most 128 samples.
- TIMEOUT, 15, maximum WAIT cycles for val_out before abort.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  reset, asynchronous, active-low.
- start  in  1  single-cycle request to begin a burst.
- cfg_dly  in  DLY_W  cycles clk_launch leads clk_capture; 0 is treated as 1.
- cfg_log2_s  in  3  burst length exponent k; samples = 2^k.
- clk_launch  out  1  launch edge to the TDC.
- clk_capture  out  1  capture edge to the TDC.
- val_in_o  out  1  valid input to the TDC.
- hw_i  in  HW_W  Hamming weight from the TDC.
- val_out_i  in  1  TDC result valid.
- busy  out  1  high from ARM through RELAX of the last sample.
- done  out  1  one-cycle pulse in the DONE state.
- acc_sum  out  HW_W+MAX_LOG2_S  sum of the accepted samples.
- hw_min  out  HW_W  minimum accepted sample.
- hw_max  out  HW_W  maximum accepted sample.
- timeout_err  out  1  sticky; set when a burst is aborted.

Behaviour:
- Reset (async assert, sync release): state IDLE; all outputs 0, including hw_min and timeout_err; counters 0.
- All outputs are registered; there is no combinational path from any input to any output.
- IDLE: start=1 latches cfg_dly (0 becomes 1) and cfg_log2_s. It clears acc_sum=0, hw_max=0, timeout_err=0, and loads hw_min=N. Next state ARM.
- ARM (1 cycle): val_in_o=1, both clocks 0. Next state LAUNCH with dly_cnt=1.
- LAUNCH (cfg_dly cycles): clk_launch=1, val_in_o=1. When dly_cnt==cfg_dly, go to CAPTURE; otherwise dly_cnt++.
- CAPTURE (1 cycle): clk_launch=1, clk_capture=1, val_in_o=1. Next state WAIT with to_cnt=0.
- WAIT: both clocks 0, val_in_o=0.
  - If val_out_i=1: accept hw_i. acc_sum += hw_i; hw_min = min(hw_min, hw_i); hw_max = max(hw_max, hw_i); samp_cnt++. Next state RELAX.
  - Else, if to_cnt==TIMEOUT-1: set timeout_err=1 and go to DONE. The partial sum and min/max are held.
  - Else to_cnt++.
- RELAX (1 cycle): all TDC drives 0.
  - If samp_cnt == 2^k, go to DONE.
  - Otherwise go to ARM for the next sample.
- DONE (1 cycle): done=1, busy=0. Next state IDLE. Results hold until the next accepted start.
- busy is 1 in ARM, LAUNCH, CAPTURE, WAIT and RELAX; 0 in IDLE and DONE.
- start outside IDLE is ignored, including in DONE. Config changes during a burst have no effect.
- acc_sum is wide enough for 128 × N = 8192, so it never overflows. samp_cnt is MAX_LOG2_S+1 bits wide and does not wrap.
- If val_out_i is already high on entry to WAIT, the sample is accepted in the first WAIT cycle.
- A val_out_i pulse outside WAIT is ignored.
- If rst_n is asserted mid-burst, all outputs drop to 0 immediately, including clk_launch and clk_capture. No partial result is retained.
- Per-sample latency, from ARM to RELAX inclusive: 1 + cfg_dly + 1 + (wait cycles) + 1.

Decomposition:
- Package tdc_ctrl_pkg:
  - state enum: IDLE, ARM, LAUNCH, CAPTURE, WAIT, RELAX, DONE.
  - HW_W derivation function.
  - default TIMEOUT.
  - accumulator width constant.
- Sub-module tdc_hw_stats:
  - ports: clk, rst_n, clr, acc_en, hw_i.
  - registers acc_sum, hw_min and hw_max.
  - clr loads 0 / N / 0.
- The FSM and counters remain in tdc_meas_seq.

Test Plan:
- Single sample: cfg_dly=3, k=0; the TDC model returns val_out 2 cycles after capture with hw=37.
  - clk_launch high 4 cycles, clk_capture high in the 4th only.
  - done occurs 9 cycles after start.
  - acc_sum=37, hw_min=37, hw_max=37, timeout_err=0.
- Burst: k=2, samples 10, 40, 25, 64 → acc_sum=139, hw_min=10, hw_max=64, exactly 4 capture pulses, one done pulse.
- cfg_dly=0 → behaves as 1: clk_launch high for exactly 2 cycles per sample.
- Timeout: the model never raises val_out.
  - WAIT lasts 15 cycles, then timeout_err=1 and done=1.
  - acc_sum=0, hw_min=64, busy returns to 0.
  - The next start clears timeout_err.
- start pulsed during WAIT and during DONE → ignored: the burst count is unchanged and no second burst runs.
- rst_n asserted while in LAUNCH → clk_launch=0 asynchronously, all outputs 0, state IDLE. A fresh burst after release completes correctly.
